// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: Q-format widths, FSM state type and result shaping.
// Result shaping depends on build macro MAC_SEQ_RELU_EN.
package mac_sequencer_pkg;

    localparam int Q_INT  = 8;
    localparam int Q_FRAC = 8;
    localparam int Q_W    = Q_INT + Q_FRAC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_seq_state_t;

    // Value loaded into the result register from the wrapped MAC sum.
    function automatic logic [Q_W-1:0] shape_result(input logic [Q_W-1:0] v);
`ifdef MAC_SEQ_RELU_EN
        return v[Q_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: issues N operand reads, steers an external MAC datapath and
// registers the final sum behind a valid/ready handshake. Build macro: MAC_SEQ_RELU_EN.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic              ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mac_reg_enable,
    output logic              mac_x_select,
    output logic              mac_w_select,
    output logic              mac_acc_loopback,
    input  logic [Q_W-1:0]    mac,
    output logic [Q_W-1:0]    result,
    output logic              result_valid,
    input  logic              result_ready
);

    mac_seq_state_t state, state_nxt;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] x_base_q;
    logic [ADDR_W-1:0] w_base_q;
    logic              data_vld;
    logic              data_first;
    logic              accept;
    logic              last_issue;

    assign accept     = (state == IDLE) && start && !clear;
    assign last_issue = (idx == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ready        = 1'b0;
        mem_en       = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = (len == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                mem_en = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Memory data lands one cycle after each read strobe; the flags track that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            idx        <= '0;
            x_base_q   <= '0;
            w_base_q   <= '0;
            data_vld   <= 1'b0;
            data_first <= 1'b0;
            result     <= '0;
        end else begin
            data_vld   <= mem_en && !clear;
            data_first <= mem_en && (idx == '0) && !clear;
            if (accept) begin
                len_q    <= len;
                x_base_q <= x_base;
                w_base_q <= w_base;
                idx      <= '0;
            end else if (clear) begin
                idx <= '0;
            end else if (state == ISSUE) begin
                idx <= idx + LEN_W'(1);
            end
            // The last data cycle always coincides with DRAIN.
            if (accept && (len == '0))
                result <= '0;
            else if (!clear && data_vld && (state == DRAIN))
                result <= shape_result(mac);
        end
    end

    assign x_addr           = mem_en ? x_base_q + ADDR_W'(idx) : '0;
    assign w_addr           = mem_en ? w_base_q + ADDR_W'(idx) : '0;
    assign mac_reg_enable   = 1'b0;
    assign mac_x_select     = data_vld;
    assign mac_w_select     = data_vld;
    assign mac_acc_loopback = data_vld && !data_first;

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: operand memory address width.
REQ-002 Parameter LEN_W, default 8: vector length field width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  job request; accepted only when start & ready.
REQ-006 clear  input  1  synchronous abort; returns to IDLE.
REQ-007 len  input  LEN_W  vector length N, sampled at start acceptance.
REQ-008 x_base, w_base  input  ADDR_W each  operand base addresses, sampled at start acceptance.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 mem_en  output  1  read strobe for x and w memories, which have 1-cycle read latency.
REQ-011 x_addr, w_addr  output  ADDR_W each  operand read addresses.
REQ-012 mac_reg_enable, mac_x_select, mac_w_select, mac_acc_loopback  output  1 each  MAC datapath controls.
REQ-013 mac  input  Q_INT+Q_FRAC  combinational MAC sum from the datapath.
REQ-014 result  output  Q_INT+Q_FRAC  registered dot product.
REQ-015 result_valid  output  1 / result_ready  input  1  valid/ready output handshake.

Function
REQ-016 The FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE transitions: start accepted with N>=1 goes to ISSUE; start accepted with N=0 goes to DONE with result=0.
REQ-018 ISSUE SHALL last exactly N cycles with mem_en=1 and x_addr=x_base+i, w_addr=w_base+i for i=0..N-1; addresses wrap modulo 2^ADDR_W.
REQ-019 DRAIN SHALL last exactly 1 cycle with mem_en=0, then go to DONE.
REQ-020 A data cycle is the cycle after each mem_en=1 cycle; mac_x_select=1 and mac_w_select=1 in every data cycle.
REQ-021 mac_acc_loopback SHALL be 0 in the first data cycle and 1 in later data cycles.
REQ-022 mac_reg_enable SHALL be 0 at all times; all datapath controls SHALL be 0 outside data cycles.
REQ-023 In the last data cycle, result SHALL register mac; mac is wrapped to Q_INT+Q_FRAC bits and is not saturated.
REQ-024 DONE SHALL hold result_valid=1 and a stable result until result_ready=1, then go to IDLE on the next edge.
REQ-025 Latency: if start is accepted at cycle 0 with N>=1, result_valid SHALL rise at cycle N+2.
REQ-026 Back-to-back jobs: after the handshake cycle, ready=1 for one cycle; no job overlap is permitted.
REQ-027 start while not ready SHALL be ignored, and len, x_base and w_base SHALL not be resampled.
REQ-028 clear in any state SHALL go to IDLE next cycle, deassert result_valid and leave result unchanged; clear has priority over start.

Reset
REQ-029 While reset=0: state=IDLE, ready=1, result=0, result_valid=0, mem_en=0, addresses=0, all MAC controls=0, internal counter=0.
REQ-030 Reset asserted mid-job SHALL abort the job immediately, with no partial result emitted.

Configuration
REQ-031 With MAC_SEQ_RELU_EN defined, result SHALL register 0 when mac is negative (MSB=1) and mac otherwise.
REQ-032 Without MAC_SEQ_RELU_EN, result SHALL register mac unmodified; the interface is identical in both builds.

Structure
REQ-033 Q_INT and Q_FRAC SHALL come from package definitions; the state enum typedef mac_seq_state_t SHALL be added there.
REQ-034 The block SHALL have no sub-module: it is one FSM plus an index counter and a data-valid/first-cycle pipeline flag, and the MAC datapath is instantiated by the parent.

Verification (Q8.8)
REQ-035 N=3, x=[1.0,2.0,3.0], w=[0.5,0.5,0.5] -> result=0x0300 at cycle 5; loopback pattern 0,1,1.
REQ-036 N=0 -> result_valid at cycle 1 with result=0; mem_en never asserted.
REQ-037 x_base=0xFE, N=4 -> x_addr sequence FE,FF,00,01.
REQ-038 result_ready held 0 for 10 cycles -> result stable and no new start accepted; after release, ready=1 next cycle.
REQ-039 clear at ISSUE cycle 2 of N=5 -> IDLE next cycle, result_valid stays 0, mem_en drops; reset mid-job behaves likewise.
REQ-040 x=[-1.0], w=[1.0] -> result=0xFF00 without MAC_SEQ_RELU_EN and 0x0000 with it.
